// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   Double-flop synchronizes rxd_i, qualifies the start bit at half-bit time
//   (rejecting short glitches), samples each data bit at mid-bit, assembles
//   the byte LSB-first and reports it with a one-cycle strobe. A low stop bit
//   raises a one-cycle framing-error strobe and the receiver then waits for
//   the line to return high before re-arming, so a break is not decoded as
//   a stream of zero bytes.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       synchronous active-high reset
//   rxd_i         asynchronous serial input, idle high
//   data_out_o    last correctly framed byte (held until the next good one)
//   data_valid_o  one-cycle pulse, data_out_o is new in this cycle
//   frame_err_o   one-cycle pulse, stop bit sampled low
//   busy_o        high whenever the receiver is not idle
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | line idle, waiting for a synchronized low level
// S_START    | start bit seen, confirm it is still low at half-bit
// S_DATA     | sampling the 8 data bits at mid-bit, LSB first
// S_STOP     | sampling the stop bit; good frame or framing error
// S_BRK_WAIT | stop bit was low, wait for the line to go high again

module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rxd_i,
  output logic [7:0] data_out_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rxd_s;

  assign rxd_s = sync_q[1];

  // Sync flops reset to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxd_s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      // Leaving at mid-stop-bit re-arms in time for a start bit that
      // follows the stop bit with no idle gap.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BRK_WAIT;
          end
        end
      end

      S_BRK_WAIT: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16. A serial-line driver
// task plays the role of the transmitter; each frame it sends queues the
// event the receiver should report (good byte or framing error) together
// with the cycle it is due. A monitor pops those events as the receiver
// strobes and compares kind, value, held data and latency.

module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int LATENCY = 2 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rxd_i       (rxd),
    .data_out_o  (data_out),
    .data_valid_o(data_valid),
    .frame_err_o (frame_err),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] val;
    longint     due;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  longint     cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected event.
  always @(negedge clk) begin
    if (!reset && (data_valid || frame_err)) begin
      ev_t    e;
      longint d;
      chk("strobe_exclusive", longint'(data_valid && frame_err), 0);
      if (data_valid) valid_cnt++;
      if (frame_err)  ferr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind_ferr", longint'(frame_err), longint'(e.err));
        d = cyc - e.due;
        chk("latency_within_2", longint'(d >= -2 && d <= 2), 1);
        if (data_valid && !e.err) begin
          chk("data_out", longint'(data_out), longint'(e.val));
          last_good = e.val;
        end else begin
          chk("data_out_held", longint'(data_out), longint'(last_good));
        end
      end
    end
  end

  // Caller must be aligned at posedge+1; returns aligned the same way.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    ev_t        e;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      if (i == 0) begin
        e.err = !stop_bit;
        e.val = b;
        e.due = cyc + LATENCY;
        exp_q.push_back(e);
      end
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_drained(input string tag);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 4 * CPB) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk(tag, longint'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int         busy_cycles;
    int         sent;
    logic [9:0] bits;
    logic [7:0] b;

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busy",       longint'(busy), 0);
    chk("rst_data_out",   longint'(data_out), 0);
    chk("rst_data_valid", longint'(data_valid), 0);
    chk("rst_frame_err",  longint'(frame_err), 0);
    reset = 1'b0;
    idle(10);

    // Single frame
    send_frame(8'hA5, 1'b1);
    expect_drained("a5_drain");
    idle(5);
    chk("a5_busy_after", longint'(busy), 0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    expect_drained("b2b_drain");
    idle(20);

    // Framing error followed by a held-low break
    send_frame(8'h55, 1'b0);
    rxd = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("break_busy_during", longint'(busy), 1);
    idle(20);
    chk("break_busy_after", longint'(busy), 0);
    send_frame(8'h12, 1'b1);
    expect_drained("break_drain");
    idle(20);

    // 5-cycle glitch on idle line
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rxd = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    @(posedge clk);
    #1;
    chk("glitch_busy_about_8", longint'(busy_cycles >= 6 && busy_cycles <= 10), 1);
    chk("glitch_busy_low", longint'(busy), 0);
    send_frame(8'h81, 1'b1);
    expect_drained("glitch_drain");
    idle(20);

    // Reset mid-frame during data bit 4
    b = 8'hC3;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = bits[5];
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    rxd   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_good = 8'h00;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_data_out", longint'(data_out), 0);
    idle(40);
    send_frame(8'h7E, 1'b1);
    expect_drained("midrst_drain");
    idle(20);

    // Loopback-style sweep of all byte values with random idle gaps
    sent = 0;
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b1);
      sent++;
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 40)));
    end
    // Extra random bytes, back-to-back
    for (int k = 0; k < 16; k++) begin
      send_frame(8'($urandom), 1'b1);
      sent++;
    end
    expect_drained("sweep_drain");
    idle(20);

    chk("total_valid", longint'(valid_cnt), longint'(sent + 1 + 3 + 1 + 1 + 1));
    chk("total_ferr", longint'(ferr_cnt), 1);
    chk("final_busy", longint'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
